serial_cmd_rx: RTL
==================

# serial_cmd_rx

Host-to-board command receiver for the lidar frame viewer. It receives 8N1 UART bytes on the `rs232_rx` pin and parses fixed-length checksummed command frames. It holds the acquisition configuration registers (`time_set`, `resolution`, `enable`, `serialsend_flag`) that feed SamplingControl and SerialSend in place of the hard-wired constants. It is the receive-side counterpart of the existing `rs232_tx` serial sender and uses the same baud rate and clock.

## Interface

**Parameters**
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `BIT_CNT`, default CLK_FREQ/BAUD (434): clocks per bit, integer division.
- `HALF_CNT`, default BIT_CNT/2 (217): clocks from start edge to start-bit check.
- `TIMEOUT_CLKS`, default 500_000: inter-byte timeout in clocks (10 ms).

**Ports**
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs232_rx` in 1: UART RX pin, asynchronous, idle high.
- `time_set` out 26: sample period setting. Reset value 22000.
- `resolution` out 9: resolution setting. Reset value 10.
- `enable` out 1: sampling enable. Reset value 1.
- `serialsend_flag` out 1: protocol-send flag for SerialSend. Reset value 1.
- `rx_byte` out 8: last received byte. Reset value 0.
- `rx_byte_valid` out 1: one-cycle strobe, `rx_byte` is new. Reset value 0.
- `cmd_valid` out 1: one-cycle strobe, a frame was accepted and applied. Reset value 0.
- `cmd_err` out 1: one-cycle strobe, a frame was rejected. Reset value 0.

## Operation

**Input synchroniser**
- `rs232_rx` passes through a 2-flop synchroniser to give `rx_s`. Both flops reset to 1.

**UART receiver states: R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI**
- R_IDLE: when `rx_s`=0, go to R_START and clear the counter.
- R_START: after HALF_CNT clocks, sample `rx_s`.
  - If 0, go to R_DATA.
  - If 1, the start was a glitch: return to R_IDLE with no strobe.
- R_DATA: sample 8 bits, each BIT_CNT clocks after the previous sample, LSB first.
- R_STOP: sample BIT_CNT clocks after bit 7.
  - If 1, load `rx_byte`, pulse `rx_byte_valid` on the next cycle, and go to R_IDLE.
  - If 0, this is a framing error: no byte is delivered, a framing-error event goes to the parser, and the state goes to R_WAITHI.
- R_WAITHI: stay until `rx_s`=1, then go to R_IDLE.

**Frame format:** AA 55 CMD D3 D2 D1 D0 CHK
- DATA = {D3,D2,D1,D0}, big-endian 32 bits.
- CHK = (CMD+D3+D2+D1+D0) mod 256.

**Parser states: P_H0, P_H1, P_CMD, P_DATA, P_CHK.** The parser advances only on `rx_byte_valid`.
- P_H0: byte AA goes to P_H1. Any other byte stays in P_H0 silently.
- P_H1:
  - 55 goes to P_CMD.
  - AA stays in P_H1.
  - Anything else goes to P_H0 with no error.
- P_CMD: latch CMD, set sum=CMD, go to P_DATA with byte index 0.
- P_DATA: shift the byte into DATA and add it to sum (8-bit wrap). After the 4th byte, go to P_CHK.
- P_CHK: evaluate the frame and return to P_H0.
  - Accept only if CHK==sum and the command is legal (list below). On accept, update the target register and pulse `cmd_valid`.
  - Otherwise pulse `cmd_err`. All registers keep their values.

**Commands**
- 0x01: `time_set` ← DATA[25:0]. Illegal if DATA[31:26]≠0 or DATA[25:0]==0.
- 0x02: `resolution` ← DATA[8:0]. Illegal if DATA[31:9]≠0 or DATA[8:0]==0.
- 0x03: `enable` ← DATA[0]. Illegal if DATA[31:1]≠0.
- 0x04: `serialsend_flag` ← DATA[0]. Illegal if DATA[31:1]≠0.
- Any other CMD is illegal.

**Abort conditions**
- A framing error while the parser is in any state other than P_H0: pulse `cmd_err`, go to P_H0.
- Timeout: the counter clears on every `rx_byte_valid`. It counts only while the parser is not in P_H0. On reaching TIMEOUT_CLKS: pulse `cmd_err`, go to P_H0.
- Timeout and framing error in the same cycle: only one `cmd_err` pulse.

**Reset**
- Reset mid-byte or mid-frame: all state returns to R_IDLE/P_H0, all outputs return to their reset values, and the partial frame is discarded.

## Timing

- Let t0 be the first cycle with `rx_s`=0 (2 clocks after the pin falls).
  - Start check at t0+HALF_CNT.
  - Bit k (k=0..7) sampled at t0+HALF_CNT+(k+1)·BIT_CNT.
  - Stop sampled at t0+HALF_CNT+9·BIT_CNT.
  - `rx_byte_valid` high at t0+HALF_CNT+9·BIT_CNT+1 (t0+4124 at defaults).
- `cmd_valid` or `cmd_err` is asserted 1 cycle after the `rx_byte_valid` of CHK. Register updates are visible in the same cycle as `cmd_valid`.
- Back-to-back bytes with no idle gap are received without loss, because R_IDLE is re-entered mid-stop-bit.
- All strobes are exactly 1 cycle wide. At most one parser strobe is asserted per byte.

## Test plan

1. Release reset, hold `rs232_rx` high for 10k clocks. Required: `time_set`=22000, `resolution`=10, `enable`=1, `serialsend_flag`=1, no strobes.
2. Send byte 0x5A at 115200. Required: `rx_byte`=0x5A, with `rx_byte_valid` at t0+4124 for exactly 1 cycle.
3. Send AA 55 01 00 00 27 10 38. Required: `cmd_valid` 1 cycle after the last byte, `time_set`=10000. Then send AA 55 02 00 00 00 20 22. Required: `resolution`=32.
4. Send AA 55 01 00 00 27 10 39 (bad CHK). Then send AA 55 02 00 00 00 00 02 (resolution 0). Required: `cmd_err` pulse for each frame, registers unchanged.
5. Drive a 100-clock low glitch, then send a byte with its stop bit forced low. Required: no `rx_byte_valid` for either event. The receiver recovers and the next byte 0xA5 is received correctly.
6. Send AA 55 03, then idle 600k clocks. Required: `cmd_err` at 500k clocks after the 0x03 strobe, parser back in P_H0. Then assert `rst_n` low in the middle of a frame. Required: all outputs at reset values, and the next full frame is accepted.

Source files
------------

// File: rtl/serial_cmd_rx.sv
// rtl/serial_cmd_rx.sv - 8N1 UART receiver with checksummed command-frame parser and config registers
module serial_cmd_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int BIT_CNT      = CLK_FREQ / BAUD,
    parameter int HALF_CNT     = BIT_CNT / 2,
    parameter int TIMEOUT_CLKS = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rs232_rx,
    output logic [25:0] time_set,
    output logic [8:0]  resolution,
    output logic        enable,
    output logic        serialsend_flag,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        cmd_valid,
    output logic        cmd_err
);
    localparam int CW = $clog2(BIT_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
    typedef enum logic [2:0] {P_H0, P_H1, P_CMD, P_DATA, P_CHK} p_state_t;

    logic            sync1_q, rx_s_q;
    rx_state_t       rstate_q, rstate_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            ferr_q, ferr_d;

    p_state_t        pstate_q, pstate_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      sum_q, sum_d;
    logic [31:0]     data_q, data_d;
    logic [1:0]      didx_q, didx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [25:0]     time_set_q, time_set_d;
    logic [8:0]      resolution_q, resolution_d;
    logic            enable_q, enable_d;
    logic            ssf_q, ssf_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_err_q, cmd_err_d;
    logic            legal;
    logic            timeout;

    // Bit counter free-runs in every state; each state decides when to clear it.
    always_comb begin
        rstate_d   = rstate_q;
        bcnt_d     = bcnt_q + 1'b1;
        bidx_d     = bidx_q;
        shift_d    = shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                bcnt_d = '0;
                if (!rx_s_q) rstate_d = R_START;
            end
            R_START: begin
                if (bcnt_q == CW'(HALF_CNT - 1)) begin
                    bcnt_d   = '0;
                    bidx_d   = '0;
                    rstate_d = rx_s_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (bcnt_q == CW'(BIT_CNT - 1)) begin
                    bcnt_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == 3'd7) rstate_d = R_STOP;
                end
            end
            R_STOP: begin
                if (bcnt_q == CW'(BIT_CNT - 1)) begin
                    bcnt_d = '0;
                    if (rx_s_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rstate_d   = R_IDLE;
                    end else begin
                        ferr_d   = 1'b1;
                        rstate_d = R_WAITHI;
                    end
                end
            end
            R_WAITHI: begin
                bcnt_d = '0;
                if (rx_s_q) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        case (cmd_q)
            8'h01:   legal = (data_q[31:26] == '0) && (data_q[25:0] != '0);
            8'h02:   legal = (data_q[31:9] == '0) && (data_q[8:0] != '0);
            8'h03,
            8'h04:   legal = (data_q[31:1] == '0);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        pstate_d     = pstate_q;
        cmd_d        = cmd_q;
        sum_d        = sum_q;
        data_d       = data_q;
        didx_d       = didx_q;
        time_set_d   = time_set_q;
        resolution_d = resolution_q;
        enable_d     = enable_q;
        ssf_d        = ssf_q;
        cmd_valid_d  = 1'b0;
        cmd_err_d    = 1'b0;
        timeout      = (pstate_q != P_H0) && !rx_valid_q && (tcnt_q == TW'(TIMEOUT_CLKS - 1));
        tcnt_d       = (pstate_q == P_H0 || rx_valid_q) ? '0 : tcnt_q + 1'b1;

        // A coincident framing error and timeout share a single abort.
        if (pstate_q != P_H0 && (ferr_q || timeout)) begin
            cmd_err_d = 1'b1;
            pstate_d  = P_H0;
            tcnt_d    = '0;
        end else if (rx_valid_q) begin
            case (pstate_q)
                P_H0: if (rx_byte_q == 8'hAA) pstate_d = P_H1;
                P_H1: begin
                    if (rx_byte_q == 8'h55)      pstate_d = P_CMD;
                    else if (rx_byte_q != 8'hAA) pstate_d = P_H0;
                end
                P_CMD: begin
                    cmd_d    = rx_byte_q;
                    sum_d    = rx_byte_q;
                    didx_d   = '0;
                    pstate_d = P_DATA;
                end
                P_DATA: begin
                    data_d = {data_q[23:0], rx_byte_q};
                    sum_d  = sum_q + rx_byte_q;
                    didx_d = didx_q + 1'b1;
                    if (didx_q == 2'd3) pstate_d = P_CHK;
                end
                P_CHK: begin
                    pstate_d = P_H0;
                    if (rx_byte_q == sum_q && legal) begin
                        cmd_valid_d = 1'b1;
                        case (cmd_q)
                            8'h01:   time_set_d   = data_q[25:0];
                            8'h02:   resolution_d = data_q[8:0];
                            8'h03:   enable_d     = data_q[0];
                            default: ssf_d        = data_q[0];
                        endcase
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: pstate_d = P_H0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rstate_q     <= R_IDLE;
            bcnt_q       <= '0;
            bidx_q       <= '0;
            shift_q      <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            ferr_q       <= 1'b0;
            pstate_q     <= P_H0;
            cmd_q        <= '0;
            sum_q        <= '0;
            data_q       <= '0;
            didx_q       <= '0;
            tcnt_q       <= '0;
            time_set_q   <= 26'd22000;
            resolution_q <= 9'd10;
            enable_q     <= 1'b1;
            ssf_q        <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            sync1_q      <= rs232_rx;
            rx_s_q       <= sync1_q;
            rstate_q     <= rstate_d;
            bcnt_q       <= bcnt_d;
            bidx_q       <= bidx_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            ferr_q       <= ferr_d;
            pstate_q     <= pstate_d;
            cmd_q        <= cmd_d;
            sum_q        <= sum_d;
            data_q       <= data_d;
            didx_q       <= didx_d;
            tcnt_q       <= tcnt_d;
            time_set_q   <= time_set_d;
            resolution_q <= resolution_d;
            enable_q     <= enable_d;
            ssf_q        <= ssf_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign time_set        = time_set_q;
    assign resolution      = resolution_q;
    assign enable          = enable_q;
    assign serialsend_flag = ssf_q;
    assign rx_byte         = rx_byte_q;
    assign rx_byte_valid   = rx_valid_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_err         = cmd_err_q;
endmodule
